// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential shift-subtract divider.
//   state_t : controller state encoding (IDLE, CALC, FIX, DONE)
//   STATE_W : width of the state encoding
package seq_divider_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_ctrl.sv
// Divider controller: FSM, iteration counter and handshake outputs.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : operation request, honoured only in IDLE/DONE
//   load       : combinational strobe, latch operands this cycle
//   step       : combinational strobe, perform one restoring iteration
//   fix        : combinational strobe, apply signs/flags to outputs
//   busy       : registered, operation in progress
//   valid      : registered, results and flags valid
module seq_divider_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic fix,
  output logic busy,
  output logic valid
);

  import seq_divider_pkg::*;

  localparam int unsigned CW = $clog2(DW + 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          busy_next, valid_next;

  // State, counter and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
      valid <= valid_next;
    end
  end

  // Next-state, counter and strobe decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = busy;
    valid_next = valid;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = CW'(DW);
          busy_next  = 1'b1;
          valid_next = 1'b0;
          state_next = CALC;
        end
      end
      CALC: begin
        step     = 1'b1;
        cnt_next = cnt - CW'(1);
        // Last quotient bit is produced on the edge where cnt goes 1 -> 0
        if (cnt == CW'(1)) state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        busy_next  = 1'b0;
        valid_next = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Parametrised sequential restoring divider, signed or unsigned per operation.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, sampled only when busy=0
//   signed_mode  : 0 unsigned, 1 two's-complement
//   dividendin   : DW-bit dividend, sampled with start
//   divisorin    : VW-bit divisor, sampled with start
//   quotient     : DW-bit result
//   remainder    : VW-bit result (sign follows dividend)
//   valid, busy  : handshake
//   dbz, ovf     : divide-by-zero and signed-overflow flags, valid with valid
module seq_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [DW-1:0] dividendin,
  input  logic [VW-1:0] divisorin,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          valid,
  output logic          busy,
  output logic          dbz,
  output logic          ovf
);

  import seq_divider_pkg::*;

  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  logic          load, step, fix;
  logic [DW-1:0] dq;        // dividend magnitude, becomes quotient magnitude
  logic [VW-1:0] dvs_mag;
  logic [VW-1:0] prem;      // partial remainder
  logic          dvd_neg, dvs_neg, smode;

  logic [DW-1:0] dvd_abs_c;
  logic [VW-1:0] dvs_abs_c;
  logic [VW:0]   shifted_c, trial_c;
  logic          borrow_c;
  logic          dbz_c, ovf_c;
  logic [DW-1:0] q_fix_c;
  logic [VW-1:0] r_fix_c;

  seq_divider_ctrl #(.DW(DW)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .busy  (busy),
    .valid (valid)
  );

  // Operand magnitudes; -2^(DW-1) negates to itself, which is correct as unsigned
  always_comb begin
    dvd_abs_c = (signed_mode && dividendin[DW-1]) ? (~dividendin + DW'(1)) : dividendin;
    dvs_abs_c = (signed_mode && divisorin[VW-1])  ? (~divisorin + VW'(1))  : divisorin;
  end

  // One restoring iteration: shift in next dividend bit, trial subtract
  always_comb begin
    shifted_c = {prem, dq[DW-1]};
    trial_c   = shifted_c - {1'b0, dvs_mag};
    borrow_c  = shifted_c < {1'b0, dvs_mag};
  end

  // Sign fix-up and special cases
  always_comb begin
    dbz_c   = (dvs_mag == '0);
    // Divisor -1 leaves dq equal to the dividend magnitude
    ovf_c   = smode && dvd_neg && dvs_neg && (dvs_mag == VW'(1)) && (dq == DMIN);
    q_fix_c = (smode && (dvd_neg ^ dvs_neg)) ? (~dq + DW'(1)) : dq;
    r_fix_c = (smode && dvd_neg) ? (~prem + VW'(1)) : prem;
    if (dbz_c) begin
      q_fix_c = '1;
      r_fix_c = '0;
    end else if (ovf_c) begin
      q_fix_c = DMIN;
      r_fix_c = '0;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dq        <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      smode     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else if (load) begin
      dq      <= dvd_abs_c;
      dvs_mag <= dvs_abs_c;
      prem    <= '0;
      dvd_neg <= signed_mode & dividendin[DW-1];
      dvs_neg <= signed_mode & divisorin[VW-1];
      smode   <= signed_mode;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
    end else if (step) begin
      prem <= borrow_c ? VW'(shifted_c) : VW'(trial_c);
      dq   <= {dq[DW-2:0], ~borrow_c};
    end else if (fix) begin
      quotient  <= q_fix_c;
      remainder <= r_fix_c;
      dbz       <= dbz_c;
      ovf       <= ovf_c;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed cases on an 8/7 instance, random sweep on a 12/5 instance.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_sm;
  logic [7:0] a_dvd, a_q;
  logic [6:0] a_dvs, a_r;
  logic       a_valid, a_busy, a_dbz, a_ovf;

  logic        b_start, b_sm;
  logic [11:0] b_dvd, b_q;
  logic [4:0]  b_dvs, b_r;
  logic        b_valid, b_busy, b_dbz, b_ovf;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DW(8), .VW(7)) dut_a (
    .clk(clk), .reset(rst), .start(a_start), .signed_mode(a_sm),
    .dividendin(a_dvd), .divisorin(a_dvs), .quotient(a_q), .remainder(a_r),
    .valid(a_valid), .busy(a_busy), .dbz(a_dbz), .ovf(a_ovf)
  );

  seq_divider #(.DW(12), .VW(5)) dut_b (
    .clk(clk), .reset(rst), .start(b_start), .signed_mode(b_sm),
    .dividendin(b_dvd), .divisorin(b_dvs), .quotient(b_q), .remainder(b_r),
    .valid(b_valid), .busy(b_busy), .dbz(b_dbz), .ovf(b_ovf)
  );

  // Reference: integer division with truncation, plus the special cases
  function automatic void ref_div(input int dw, input int vw, input bit sm,
                                  input longint a_raw, input longint b_raw,
                                  output longint q, output longint r,
                                  output bit z, output bit o);
    longint a, b, qm, rm;
    a  = a_raw;
    b  = b_raw;
    qm = (longint'(1) << dw) - 1;
    rm = (longint'(1) << vw) - 1;
    if (sm && a_raw[dw-1]) a = a_raw - (longint'(1) << dw);
    if (sm && b_raw[vw-1]) b = b_raw - (longint'(1) << vw);
    z = (b == 0);
    o = 1'b0;
    if (z) begin
      q = qm;
      r = 0;
    end else if (sm && a == -(longint'(1) << (dw - 1)) && b == -1) begin
      o = 1'b1;
      q = longint'(1) << (dw - 1);
      r = 0;
    end else begin
      q = (a / b) & qm;
      r = (a % b) & rm;
    end
  endfunction

  // Run one operation on instance A (which=0) or B (which=1); returns outputs at first valid
  task automatic run_op(input bit which, input bit sm, input logic [11:0] dvd,
                        input logic [11:0] dvs, input int glitch,
                        output logic [11:0] q, output logic [11:0] r,
                        output logic z, output logic o, output int lat,
                        output logic v_e0);
    logic vv;
    @(negedge clk);
    if (which) begin
      b_sm = sm; b_dvd = dvd; b_dvs = dvs[4:0]; b_start = 1'b1;
    end else begin
      a_sm = sm; a_dvd = dvd[7:0]; a_dvs = dvs[6:0]; a_start = 1'b1;
    end
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
    v_e0 = which ? b_valid : a_valid;
    lat = 0;
    vv = 1'b0;
    while (!vv && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      a_start = 1'b0;
      vv = which ? b_valid : a_valid;
      // Request with different operands mid-operation; must be ignored
      if (!vv && lat == glitch && !which) begin
        a_start = 1'b1; a_sm = 1'b0; a_dvd = 8'd9; a_dvs = 7'd3;
      end
    end
    q = which ? b_q : 12'(a_q);
    r = which ? 12'(b_r) : 12'(a_r);
    z = which ? b_dbz : a_dbz;
    o = which ? b_ovf : a_ovf;
  endtask

  logic [11:0] oq, orr;
  logic        oz, oo, ov0;
  int          olat;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({a_q, a_r, a_valid, a_busy, a_dbz, a_ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_a: got q=%0h r=%0h v=%0b b=%0b dbz=%0b ovf=%0b, want all 0",
               a_q, a_r, a_valid, a_busy, a_dbz, a_ovf);
    end
    checks++;
    if ({b_q, b_r, b_valid, b_busy, b_dbz, b_ovf} !== 21'd0) begin
      errors++;
      $display("FAIL reset_b: got q=%0h r=%0h v=%0b b=%0b dbz=%0b ovf=%0b, want all 0",
               b_q, b_r, b_valid, b_busy, b_dbz, b_ovf);
    end
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 1'b0, 12'd200, 12'd7, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'd28, 12'd4, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL unsigned_200_7: got q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d, want q=28 r=4 dbz=0 ovf=0 lat=9",
               oq, orr, oz, oo, olat);
    end
    run_op(1'b0, 1'b0, 12'd255, 12'd127, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'd2, 12'd1, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL unsigned_255_127: got q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d, want q=2 r=1 lat=9",
               oq, orr, oz, oo, olat);
    end
  endtask

  task automatic test_signed();
    run_op(1'b0, 1'b1, 12'h09C, 12'h007, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'h0F2, 12'h07E, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL signed_m100_7: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d, want q=f2 r=7e lat=9",
               oq, orr, oz, oo, olat);
    end
    run_op(1'b0, 1'b1, 12'd100, 12'h079, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'h0F2, 12'h002, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL signed_100_m7: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d, want q=f2 r=2 lat=9",
               oq, orr, oz, oo, olat);
    end
  endtask

  task automatic test_dbz();
    for (int m = 0; m < 2; m++) begin
      run_op(1'b0, m[0], 12'd100, 12'd0, 0, oq, orr, oz, oo, olat, ov0);
      checks++;
      if ({oq, orr, oz, oo} !== {12'h0FF, 12'h000, 2'b10} || olat != 9) begin
        errors++;
        $display("FAIL dbz_mode%0d: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d, want q=ff r=0 dbz=1 ovf=0 lat=9",
                 m, oq, orr, oz, oo, olat);
      end
    end
  endtask

  task automatic test_ovf();
    run_op(1'b0, 1'b1, 12'h080, 12'h07F, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'h080, 12'h000, 2'b01} || olat != 9) begin
      errors++;
      $display("FAIL ovf_signed: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d, want q=80 r=0 dbz=0 ovf=1 lat=9",
               oq, orr, oz, oo, olat);
    end
    run_op(1'b0, 1'b0, 12'h080, 12'h07F, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'h001, 12'h001, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL ovf_unsigned: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d, want q=1 r=1 ovf=0 lat=9",
               oq, orr, oz, oo, olat);
    end
  endtask

  task automatic test_start_ignored();
    run_op(1'b0, 1'b0, 12'd200, 12'd7, 3, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'd28, 12'd4, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL start_while_busy: got q=%0d r=%0d lat=%0d, want q=28 r=4 lat=9", oq, orr, olat);
    end
    // Nothing may have been queued behind the ignored request
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_busy, a_q} !== {2'b10, 8'd28}) begin
      errors++;
      $display("FAIL start_no_queue: got v=%0b busy=%0b q=%0d, want v=1 busy=0 q=28", a_valid, a_busy, a_q);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b0, 12'd255, 12'd127, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if (ov0 !== 1'b0 || {oq, orr} !== {12'd2, 12'd1} || olat != 9) begin
      errors++;
      $display("FAIL back_to_back: got v_after_start=%0b q=%0d r=%0d lat=%0d, want v=0 q=2 r=1 lat=9",
               ov0, oq, orr, olat);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_sm = 1'b0; a_dvd = 8'd200; a_dvs = 7'd7; a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({a_q, a_r, a_valid, a_busy, a_dbz, a_ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: got q=%0h r=%0h v=%0b b=%0b dbz=%0b ovf=%0b, want all 0",
               a_q, a_r, a_valid, a_busy, a_dbz, a_ovf);
    end
    run_op(1'b0, 1'b0, 12'd9, 12'd3, 0, oq, orr, oz, oo, olat, ov0);
    checks++;
    if ({oq, orr, oz, oo} !== {12'd3, 12'd0, 2'b00} || olat != 9) begin
      errors++;
      $display("FAIL after_reset_9_3: got q=%0d r=%0d lat=%0d, want q=3 r=0 lat=9", oq, orr, olat);
    end
  endtask

  task automatic test_random();
    longint eq, er;
    bit     ez, eo;
    bit     sm;
    logic [11:0] a;
    logic [11:0] b;
    for (int i = 0; i < 160; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 12'($urandom_range(0, 4095));
      b  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 31));
      if (i % 20 == 5) begin
        sm = 1'b1; a = 12'h800; b = 12'h01F;
      end
      ref_div(12, 5, sm, longint'(a), longint'(b), eq, er, ez, eo);
      run_op(1'b1, sm, a, b, 0, oq, orr, oz, oo, olat, ov0);
      checks++;
      if ({oq, orr, oz, oo} !== {12'(eq), 12'(er), ez, eo} || olat != 13 || ov0 !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d sm=%0b a=%0h b=%0h: got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d v0=%0b, want q=%0h r=%0h dbz=%0b ovf=%0b lat=13 v0=0",
                 i, sm, a, b, oq, orr, oz, oo, olat, ov0, 12'(eq), 12'(er), ez, eo);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_sm = 1'b0; a_dvd = '0; a_dvs = '0;
    b_start = 1'b0; b_sm = 1'b0; b_dvd = '0; b_dvs = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_ovf();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential shift-subtract divider; next generation of the fixed 8-by-7-bit unsigned divider. Adds:
- configurable operand widths;
- per-operation signed/unsigned mode;
- divide-by-zero and signed-overflow flags;
- an explicit busy/valid handshake.

It sits beside the arithmetic blocks and is driven by a host FSM that issues `start` and consumes results on `valid`.

## Interface
- `DW`, default 8: dividend and quotient width, ≥ 2.
- `VW`, default 7: divisor and remainder width, 2 ≤ `VW` ≤ `DW`.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `signed_mode`  in  1  0: unsigned; 1: two's-complement operands and results.
- `dividendin`  in  `DW`  dividend; sampled with `start`.
- `divisorin`  in  `VW`  divisor; sampled with `start`.
- `quotient`  out  `DW`  result; reset 0.
- `remainder`  out  `VW`  result; reset 0.
- `valid`  out  1  results and flags valid; reset 0.
- `busy`  out  1  operation in progress; reset 0.
- `dbz`  out  1  divide-by-zero flag; reset 0.
- `ovf`  out  1  signed overflow flag; reset 0.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE. Reset enters IDLE.
- **IDLE/DONE + `start`=1:**
  - latch operand magnitudes (abs value when `signed_mode`=1), both sign bits and `signed_mode`;
  - clear the partial remainder; counter := `DW`;
  - `valid`:=0, `busy`:=1; go to CALC.
- **CALC:** restoring algorithm, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by one, bringing in the next dividend bit.
  - Trial-subtract the divisor magnitude at `VW`+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; leave for FIX when it reaches 0.
- **FIX:** apply signs and flags, then go to DONE.
  - Sign rules: quotient sign = XOR of the operand signs; remainder sign = dividend sign (truncating division).
  - Invariant: dividend = quotient*divisor + remainder.
  - Set `busy`:=0, `valid`:=1.
- **DONE:** outputs held stable, `valid`=1 until the next accepted `start` or `reset`.
- **Divide by zero** (divisor = 0): runs the full latency; `quotient` = all ones, `remainder` = 0, `dbz`=1.
- **Signed overflow** (`signed_mode`=1, dividend = -2^(`DW`-1), divisor = -1):
  - `quotient` = -2^(`DW`-1) (wrapped), `remainder` = 0, `ovf`=1.
- **Flags:** `dbz` and `ovf` are cleared on accepted `start`; both are valid only with `valid`.
- **Width rules:**
  - The unsigned remainder is < divisor, so it fits `VW` bits.
  - The signed remainder magnitude is < 2^(`VW`-1), so it fits `VW` bits signed.
  - Taking the magnitude of -2^(`DW`-1) needs no extra bit, since it is held as unsigned `DW` bits.

## Timing
- `start` sampled at edge E0 → CALC covers edges E1..E`DW` → FIX at E(`DW`+1).
- `valid` is high after E(`DW`+1). Latency is `DW`+1 cycles, fixed regardless of operands or flags.
- `busy` is high from after E0 until after E(`DW`+1).
- `start` while `busy`=1 is ignored; there is no queueing.
- Back-to-back: `start` in DONE is accepted at once; `valid` drops the next cycle.
- Operand inputs are don't-care except in the `start`-accept cycle.
- `reset` mid-operation: next edge returns to IDLE, with all outputs 0 and the operation discarded.
- `reset` has priority over `start` in the same cycle.

## Structure
- Package `seq_divider_pkg`: state enum (IDLE, CALC, FIX, DONE) and the state encoding width.
- Sub-module `seq_divider_ctrl`: FSM, iteration counter, and the `busy`/`valid` outputs.
  - It issues `load`, `step` and `fix` strobes.
- The datapath (registers, subtractor, sign fix-up) stays in the top level.

## Test plan
- Unsigned, `DW`=8, `VW`=7: 200/7 → `quotient`=28, `remainder`=4, `valid` exactly 9 cycles after `start`; 255/127 → 2 r 1.
- Signed: 0x9C (-100)/0x07 → `quotient`=0xF2 (-14), `remainder`=0x7E (-2); 100/0x79 (-7) → 0xF2 r 2.
- 100/0 in either mode → `quotient`=0xFF, `remainder`=0, `dbz`=1, `ovf`=0, same latency.
- Signed 0x80/0x7F (-128/-1) → `quotient`=0x80, `remainder`=0, `ovf`=1; the same operands unsigned → 1 r 1, `ovf`=0.
- Start handling:
  - `start` pulsed on cycle 3 of a running operation → ignored, first result unchanged;
  - `start` in DONE → new result after 9 cycles, `valid` low in between.
- Reset handling:
  - `reset` asserted at cycle 4 of CALC → next cycle all outputs 0 and state IDLE;
  - a following 9/3 operation → 3 r 0.
- Randomised sweep at `DW`=12, `VW`=5 against a reference model, both modes.
